// File: rtl/byte_word_packer_pkg.sv
// Shared definitions for the byte-to-word packer: FSM encoding, byte width,
// and the byte-enable helper used when a partial word is flushed.
package byte_word_packer_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic {
    ST_ACC   = 1'b0,
    ST_FLUSH = 1'b1
  } state_t;

  // Lane enable for a flushed word: lanes below the byte count carry data.
  function automatic logic lane_en(input int lane, input int cnt);
    return (lane < cnt);
  endfunction

endpackage

// File: rtl/byte_word_outreg.sv
// One-word output holding register with valid/ready handshake.
// A load always wins over a same-cycle transfer, which lets back-to-back
// words stream without a bubble.
module byte_word_outreg
  import byte_word_packer_pkg::*;
#(
  parameter  int P_NBYTES = 4,
  localparam int P_OW     = BYTE_W * P_NBYTES
) (
  input  logic                clk,
  input  logic                rst_x,
  input  logic                load,
  input  logic [P_OW-1:0]     load_data,
  input  logic [P_NBYTES-1:0] load_be,
  input  logic                i_ready,
  output logic                o_valid,
  output logic [P_OW-1:0]     o_data,
  output logic [P_NBYTES-1:0] o_be
);

  // Capture a new word on load; otherwise drop valid once downstream takes it.
  always_ff @(posedge clk or negedge rst_x) begin
    if (!rst_x) begin
      o_valid <= 1'b0;
      o_data  <= '0;
      o_be    <= '0;
    end else if (load) begin
      o_valid <= 1'b1;
      o_data  <= load_data;
      o_be    <= load_be;
    end else if (o_valid && i_ready) begin
      o_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/byte_word_packer.sv
// Packs P_NBYTES consecutive bytes (little-endian by arrival) into one word.
// A flush pulse pushes out a partially filled word with byte enables.
//
//   state    | meaning
//   ---------+------------------------------------------------------------
//   ST_ACC   | accumulating bytes into the lane buffer
//   ST_FLUSH | partial word waiting for the output slot; input is stalled
module byte_word_packer
  import byte_word_packer_pkg::*;
#(
  parameter  int P_NBYTES = 4,
  localparam int P_OW     = BYTE_W * P_NBYTES
) (
  input  logic                clk,
  input  logic                rst_x,
  input  logic                i_valid,
  input  logic [BYTE_W-1:0]   i_data,
  output logic                o_ready,
  input  logic                i_flush,
  output logic                o_valid,
  output logic [P_OW-1:0]     o_data,
  output logic [P_NBYTES-1:0] o_be,
  input  logic                i_ready
);

  localparam int CW = $clog2(P_NBYTES);
  localparam logic [CW-1:0] LAST = CW'(P_NBYTES - 1);

  state_t                              state;
  logic [CW-1:0]                       count;
  logic                                flush_pend;
  logic [P_NBYTES-1:0][BYTE_W-1:0]     acc;
  logic [P_NBYTES-1:0][BYTE_W-1:0]     acc_wr;
  logic [P_NBYTES-1:0]                 part_be;
  logic [P_NBYTES-1:0]                 load_be;
  logic                                slot_free;
  logic                                accept;
  logic                                full_load;
  logic                                flush_load;
  logic                                load;

  // The last lane may only be taken when the output slot can receive the word.
  assign slot_free  = ~o_valid | i_ready;
  assign o_ready    = ~flush_pend & ((count != LAST) | slot_free);
  assign accept     = i_valid & o_ready;
  assign full_load  = accept & (count == LAST);
  assign flush_load = (state == ST_FLUSH) & slot_free;
  assign load       = full_load | flush_load;
  assign load_be    = flush_load ? part_be : '1;

  // Accumulator view including the byte accepted this cycle.
  always_comb begin
    acc_wr = acc;
    if (accept) acc_wr[count] = i_data;
  end

  // Byte enables for a flushed word: one per byte already collected.
  always_comb begin
    part_be = '0;
    for (int i = 0; i < P_NBYTES; i++) part_be[i] = lane_en(i, int'(count));
  end

  // Accumulation and flush sequencing.
  always_ff @(posedge clk or negedge rst_x) begin
    if (!rst_x) begin
      state      <= ST_ACC;
      count      <= '0;
      flush_pend <= 1'b0;
      acc        <= '0;
    end else begin
      case (state)
        ST_ACC: begin
          if (accept) begin
            if (count == LAST) begin
              acc   <= '0;
              count <= '0;
            end else begin
              acc   <= acc_wr;
              count <= count + CW'(1);
            end
          end
          // A byte that completes the word makes the flush a no-op.
          if (i_flush && !full_load && ((count != '0) || accept)) begin
            state      <= ST_FLUSH;
            flush_pend <= 1'b1;
          end
        end
        ST_FLUSH: begin
          if (slot_free) begin
            acc        <= '0;
            count      <= '0;
            flush_pend <= 1'b0;
            state      <= ST_ACC;
          end
        end
        default: begin
          state      <= ST_ACC;
          flush_pend <= 1'b0;
        end
      endcase
    end
  end

  byte_word_outreg #(.P_NBYTES(P_NBYTES)) u_outreg (
    .clk       (clk),
    .rst_x     (rst_x),
    .load      (load),
    .load_data (acc_wr),
    .load_be   (load_be),
    .i_ready   (i_ready),
    .o_valid   (o_valid),
    .o_data    (o_data),
    .o_be      (o_be)
  );

endmodule

// File: tb/tb_byte_word_packer.sv
// Bench for byte_word_packer: directed scenarios plus random traffic, all
// checked against a queue-based reference of the packing rules.
module tb_byte_word_packer;

  localparam int N  = 4;
  localparam int OW = 8 * N;

  typedef struct {
    logic [OW-1:0] d;
    logic [N-1:0]  be;
  } word_t;

  logic          clk;
  logic          rst_x;
  logic          i_valid;
  logic [7:0]    i_data;
  logic          o_ready;
  logic          i_flush;
  logic          o_valid;
  logic [OW-1:0] o_data;
  logic [N-1:0]  o_be;
  logic          i_ready;

  int n_cmp = 0;
  int n_bad = 0;

  byte_word_packer #(.P_NBYTES(N)) dut (
    .clk     (clk),
    .rst_x   (rst_x),
    .i_valid (i_valid),
    .i_data  (i_data),
    .o_ready (o_ready),
    .i_flush (i_flush),
    .o_valid (o_valid),
    .o_data  (o_data),
    .o_be    (o_be),
    .i_ready (i_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  // Reference: bytes collected so far, words owed downstream, slot occupancy.
  logic [7:0] cur[$];
  word_t      expq[$];
  logic       m_full;
  logic       m_pend;

  function automatic word_t pack_cur(input logic full);
    word_t w;
    w.d  = '0;
    w.be = '0;
    for (int i = 0; i < cur.size(); i++) begin
      w.d  = w.d | (OW'(cur[i]) << (8 * i));
      w.be = w.be | N'(1 << i);
    end
    if (full) w.be = '1;
    return w;
  endfunction

  always @(negedge clk) begin
    logic  exp_rdy, xfer, slot, accept, load;
    word_t w;
    if (!rst_x) begin
      cur.delete();
      expq.delete();
      m_full = 1'b0;
      m_pend = 1'b0;
    end else begin
      exp_rdy = !m_pend && ((cur.size() < N - 1) || !m_full || i_ready);
      check_eq("o_ready", 64'(o_ready), 64'(exp_rdy));
      check_eq("o_valid", 64'(o_valid), 64'(m_full));
      xfer = m_full && i_ready;
      if (xfer) begin
        check_eq("xfer_depth", 64'(expq.size()), 64'd1);
        if (expq.size() > 0) begin
          check_eq("o_data", 64'(o_data), 64'(expq[0].d));
          check_eq("o_be", 64'(o_be), 64'(expq[0].be));
          void'(expq.pop_front());
        end
      end
      accept = i_valid && exp_rdy;
      slot   = !m_full || i_ready;
      load   = 1'b0;
      if (m_pend) begin
        if (slot) begin
          w = pack_cur(1'b0);
          expq.push_back(w);
          cur.delete();
          m_pend = 1'b0;
          load   = 1'b1;
        end
      end else begin
        if (accept) cur.push_back(i_data);
        if (cur.size() == N) begin
          w = pack_cur(1'b1);
          expq.push_back(w);
          cur.delete();
          load = 1'b1;
        end else if (i_flush && cur.size() > 0) begin
          m_pend = 1'b1;
        end
      end
      m_full = load ? 1'b1 : (xfer ? 1'b0 : m_full);
    end
  end

  // Present one byte (optionally with a flush in its first cycle) until taken.
  task automatic send_byte(input logic [7:0] b, input logic fl);
    int  n;
    logic took;
    n = 0;
    i_valid = 1'b1;
    i_data  = b;
    i_flush = fl;
    while (1) begin
      @(negedge clk);
      took = o_ready;
      @(posedge clk);
      #1;
      i_flush = 1'b0;
      if (took) break;
      n++;
      if (n > 50) begin
        check_eq("send_timeout", 64'(n), 64'd50);
        break;
      end
    end
    i_valid = 1'b0;
  endtask

  task automatic idle(input int cycles);
    repeat (cycles) @(posedge clk);
    #1;
  endtask

  initial begin
    rst_x   = 1'b0;
    i_valid = 1'b0;
    i_data  = 8'h00;
    i_flush = 1'b0;
    i_ready = 1'b1;

    // Reset and idle
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_o_valid", 64'(o_valid), 64'd0);
    check_eq("rst_o_data", 64'(o_data), 64'd0);
    check_eq("rst_o_be", 64'(o_be), 64'd0);
    rst_x = 1'b1;
    #1;
    check_eq("idle_o_ready", 64'(o_ready), 64'd1);
    idle(2);

    // Full word, one-cycle latency, one-cycle valid
    send_byte(8'h11, 1'b0);
    send_byte(8'h22, 1'b0);
    send_byte(8'h33, 1'b0);
    send_byte(8'h44, 1'b0);
    check_eq("full_valid", 64'(o_valid), 64'd1);
    check_eq("full_data", 64'(o_data), 64'h44332211);
    check_eq("full_be", 64'(o_be), 64'hF);
    idle(1);
    check_eq("full_valid_drop", 64'(o_valid), 64'd0);

    // Backpressure
    i_ready = 1'b0;
    for (int k = 1; k <= 7; k++) send_byte(8'(k), 1'b0);
    check_eq("bp_hold_data", 64'(o_data), 64'h04030201);
    i_valid = 1'b1;
    i_data  = 8'h08;
    idle(3);
    check_eq("bp_stall_ready", 64'(o_ready), 64'd0);
    check_eq("bp_hold_data2", 64'(o_data), 64'h04030201);
    i_ready = 1'b1;
    send_byte(8'h08, 1'b0);
    idle(3);

    // Partial flush, then a full word
    send_byte(8'hAA, 1'b0);
    send_byte(8'hBB, 1'b0);
    i_flush = 1'b1;
    idle(1);
    i_flush = 1'b0;
    idle(1);
    check_eq("pflush_valid", 64'(o_valid), 64'd1);
    check_eq("pflush_data", 64'(o_data), 64'h0000BBAA);
    check_eq("pflush_be", 64'(o_be), 64'h3);
    send_byte(8'hCC, 1'b0);
    send_byte(8'hDD, 1'b0);
    send_byte(8'hEE, 1'b0);
    send_byte(8'hFF, 1'b0);
    check_eq("after_flush_data", 64'(o_data), 64'hFFEEDDCC);
    check_eq("after_flush_be", 64'(o_be), 64'hF);
    idle(2);

    // Flush together with a byte
    send_byte(8'h10, 1'b0);
    send_byte(8'h20, 1'b0);
    send_byte(8'h30, 1'b1);
    idle(1);
    check_eq("fbyte_data", 64'(o_data), 64'h00302010);
    check_eq("fbyte_be", 64'(o_be), 64'h7);
    idle(2);
    send_byte(8'hA1, 1'b0);
    send_byte(8'hB2, 1'b0);
    send_byte(8'hC3, 1'b0);
    send_byte(8'hD4, 1'b1);
    check_eq("fword_data", 64'(o_data), 64'hD4C3B2A1);
    check_eq("fword_be", 64'(o_be), 64'hF);
    idle(3);
    check_eq("fword_no_extra", 64'(o_valid), 64'd0);

    // Asynchronous reset with a word held and a partial word pending
    i_ready = 1'b0;
    for (int k = 0; k < 4; k++) send_byte(8'hC0 + 8'(k), 1'b0);
    send_byte(8'h5A, 1'b0);
    send_byte(8'h6B, 1'b0);
    #2;
    rst_x = 1'b0;
    #1;
    check_eq("arst_o_valid", 64'(o_valid), 64'd0);
    check_eq("arst_o_data", 64'(o_data), 64'd0);
    #3;
    rst_x   = 1'b1;
    i_ready = 1'b1;
    idle(1);
    for (int k = 1; k <= 4; k++) send_byte(8'(k), 1'b0);
    check_eq("arst_after_data", 64'(o_data), 64'h04030201);
    idle(2);

    // Random traffic
    for (int c = 0; c < 3000; c++) begin
      i_valid = ($urandom_range(0, 3) != 0);
      i_data  = 8'($urandom);
      i_ready = ($urandom_range(0, 2) != 0);
      i_flush = ($urandom_range(0, 11) == 0);
      @(posedge clk);
      #1;
    end
    i_valid = 1'b0;
    i_flush = 1'b0;
    i_ready = 1'b1;
    idle(10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/byte_word_packer.md
Name: byte_word_packer

Overview:
- Downstream stage of the 8-bit registered byte stage; consumes its registered byte stream and packs P_NBYTES consecutive bytes into one output word.
- Valid/ready on both sides, one-word output register, and a flush request that emits a partial word with byte enables.
- Feeds the word-wide datapath.

Parameters:
- P_NBYTES, 4, bytes per output word (2..8).
- P_OW, 8*P_NBYTES, output word width (derived, not overridable).

Ports:
- clk  input  1  clock, rising edge.
- rst_x  input  1  reset, asynchronous, active-low.
- i_valid  input  1  input byte valid.
- i_data  input  8  input byte, taken from the upstream registered byte output.
- o_ready  output  1  packer accepts a byte this cycle.
- i_flush  input  1  single-cycle flush request pulse.
- o_valid  output  1  output word valid.
- o_data  output  P_OW  packed word; byte 0 (first received) in bits [7:0].
- o_be  output  P_NBYTES  byte enables for o_data; all ones for a full word.
- i_ready  input  1  downstream accepts the word this cycle.

Behaviour:
- Clock, reset and handshake definitions
  - Reset: asynchronous, active-low on rst_x; all state is cleared immediately on assertion.
  - Reset values: o_valid=0, o_data=0, o_be=0, accumulator=0, count=0, flush_pend=0, state=ACC.
  - Reset asserted mid-word or mid-flush discards everything; no partial word is emitted after reset.
  - Input accept = i_valid & o_ready.
  - Output transfer = o_valid & i_ready.
  - slot_free = ~o_valid | i_ready.
- Accumulation
  - The accepted byte is written into accumulator lane [count]; count increments, wrapping P_NBYTES-1 -> 0.
  - On the P_NBYTES-th byte: the word and an all-ones be load into the output register at the same clock edge. o_valid=1 the next cycle, so latency is 1 cycle from the last byte.
  - The accumulator is cleared when its word moves to the output register.
- o_ready is combinational:
  - o_ready = ~flush_pend & ((count != P_NBYTES-1) | slot_free).
  - Bytes 0..N-2 are accepted even while the output register is stalled.
- Output register
  - Holds o_data and o_be stable while o_valid & ~i_ready.
  - o_valid clears on transfer unless a new word loads in the same cycle. Back-to-back words are possible at 1 word per P_NBYTES cycles with no bubble.
- FSM states:
  - ACC: normal accumulation.
  - FLUSH: a partial word is waiting for the output slot.
- Flush handling
  - i_flush in ACC with (count>0, or a byte accepted in the same cycle): flush_pend=1, go to FLUSH. A byte accepted in that same cycle is included in the flushed word.
  - If that same-cycle byte completes a full word, it emits as a normal full word and the flush is a no-op (count becomes 0, stay in ACC).
  - i_flush with count==0 and no accepted byte: ignored.
  - FLUSH: o_ready=0. When slot_free, load the accumulator (unused lanes zero) and o_be = lanes 0..count-1 set into the output register. Then count=0, flush_pend=0, return to ACC.
  - i_flush asserted while already in FLUSH: ignored.
- Arithmetic
  - count width is clog2(P_NBYTES); no other arithmetic.
  - Byte order is little-endian by arrival.
- Behaviour on X inputs
  - i_data is ignored when i_valid=0.
  - i_valid with X data is not checked.

Decomposition:
- Shared package: state encoding localparams (ST_ACC, ST_FLUSH), the byte width constant 8, and the function computing o_be from count.
- Natural sub-module: byte_word_outreg, the output holding register with valid/ready (o_valid, o_data, o_be, load and transfer logic).
- Accumulator and FSM stay in the top.

Test Plan:
- Reset/idle: hold rst_x=0 for 3 cycles, then release with i_valid=0 -> o_valid=0, o_data=0, o_be=0, o_ready=1.
- Full word: bytes 0x11,0x22,0x33,0x44 on consecutive cycles, i_ready=1 -> one cycle after 0x44, o_valid=1, o_data=0x44332211, o_be=4'hF, for exactly 1 cycle.
- Backpressure: i_ready=0, send 8 bytes 0x01..0x08.
  - First word 0x04030201 is held stable.
  - Bytes 0x05..0x07 are accepted; o_ready=0 while 0x08 is presented.
  - Raise i_ready -> 0x04030201 transfers, then 0x08070605 follows; no byte is lost or duplicated.
- Partial flush:
  - Send 0xAA,0xBB, then i_flush pulse -> o_data=0x0000BBAA, o_be=4'b0011.
  - Next bytes 0xCC,0xDD,0xEE,0xFF -> 0xFFEEDDCC, o_be=4'hF.
- Flush plus byte in the same cycle:
  - 0x10,0x20 sent, then 0x30 with i_flush=1 -> 0x00302010, o_be=4'b0111.
  - 3 bytes, then the 4th with i_flush -> full word, no extra empty word.
- Reset mid-operation: send 0x5A,0x6B, then pulse rst_x=0 asynchronously between edges -> o_valid=0 immediately. Next 4 bytes 0x01..0x04 -> 0x04030201.
